// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared types and constants for the adder_sched block.
//   state_t  - scheduler FSM states (IDLE, SETTLE, RESP)
//   SETTLE_W - width of the settle counter (supports SETTLE_CYCLES up to 2**SETTLE_W)
//   id_w()   - requester index width, $clog2(N_REQ) with a floor of one bit
package adder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int SETTLE_W = 8;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/BypassAdder_s_c.sv
// BypassAdder_s_c: carry-skip adder. Operands are split into BLOCK-bit groups,
// each a small ripple adder; when every bit of a group propagates, the group
// carry-in bypasses the ripple chain straight to the group carry-out.
// Ports:
//   a_i, b_i  in  WIDTH  operands
//   cin_i     in  1      carry-in
//   sum_o     out WIDTH  a+b+cin modulo 2**WIDTH
//   cout_o    out 1      carry-out
module BypassAdder_s_c #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        localparam int LO = g * BLOCK;
        // The top group is narrower when WIDTH is not a multiple of BLOCK.
        localparam int BW = ((LO + BLOCK) > WIDTH) ? (WIDTH - LO) : BLOCK;

        logic          blk_cin;
        logic          blk_cout;
        logic          rip_cout;
        logic          skip;
        logic [BW-1:0] blk_sum;

        if (g == 0) begin : g_first
            assign blk_cin = cin_i;
        end else begin : g_rest
            assign blk_cin = g_blk[g-1].blk_cout;
        end

        assign {rip_cout, blk_sum} = {1'b0, a_i[LO +: BW]} + {1'b0, b_i[LO +: BW]}
                                   + {{BW{1'b0}}, blk_cin};
        assign skip                = &(a_i[LO +: BW] ^ b_i[LO +: BW]);
        assign blk_cout            = skip ? blk_cin : rip_cout;
        assign sum_o[LO +: BW]     = blk_sum;
    end

    assign cout_o = g_blk[NBLK-1].blk_cout;

endmodule

// File: rtl/adder_sched_arb.sv
// adder_sched_arb: picks one winner among the asserted request valids.
// Build option ADDER_SCHED_RR_EN:
//   defined   - round-robin, search starts one past last_i
//   undefined - fixed priority, lowest index wins (no last_i port)
// Ports:
//   req_valid_i  in  N_REQ  request valids
//   last_i       in  ID_W   previous winner (round-robin build only)
//   grant_oh_o   out N_REQ  one-hot winner, zero when nothing is valid
//   grant_idx_o  out ID_W   winner index, zero when nothing is valid
module adder_sched_arb
    import adder_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
`ifdef ADDER_SCHED_RR_EN
    input  logic [ID_W-1:0]  last_i,
`endif
    output logic [N_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]  grant_idx_o
);

    logic            found;
    logic [ID_W-1:0] cand;
`ifdef ADDER_SCHED_RR_EN
    int              pos;
`endif

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
`ifdef ADDER_SCHED_RR_EN
        pos         = 0;
        // Walk last+1, last+2, ... wrapping, so the previous winner is checked last.
        for (int off = 1; off <= N_REQ; off++) begin
            pos  = (int'(last_i) + off) % N_REQ;
            cand = ID_W'(pos);
            if (!found && req_valid_i[cand]) begin
                found             = 1'b1;
                grant_oh_o[cand]  = 1'b1;
                grant_idx_o       = cand;
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'(i);
            if (!found && req_valid_i[cand]) begin
                found             = 1'b1;
                grant_oh_o[cand]  = 1'b1;
                grant_idx_o       = cand;
            end
        end
`endif
    end

endmodule

// File: rtl/adder_sched.sv
// adder_sched: time-shares one BypassAdder_s_c among N_REQ requesters.
// Build option ADDER_SCHED_RR_EN selects round-robin (defined) or fixed
// lowest-index-first (undefined) arbitration.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source holds valid and payload stable until that edge.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot or zero)
//   req_a/req_b             packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin                 per-requester carry-in
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_sum/rsp_cout registered requester index, sum and carry-out
//   dbg_state_o             current FSM state
// The operand registers to rsp_sum/rsp_cout path is a SETTLE_CYCLES-cycle
// multicycle path: operands only change on a request transfer edge and the
// result is captured SETTLE_CYCLES edges later.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter  int N_REQ         = 4,
    parameter  int WIDTH         = 32,
    parameter  int BLOCK         = 4,
    parameter  int SETTLE_CYCLES = 2,
    localparam int ID_W          = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output state_t                 dbg_state_o
);

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]      op_a_q, op_a_d;
    logic [WIDTH-1:0]      op_b_q, op_b_d;
    logic                  op_cin_q, op_cin_d;
    logic [ID_W-1:0]       op_id_q, op_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_sum_q, rsp_sum_d;
    logic                  rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
`ifdef ADDER_SCHED_RR_EN
    logic [ID_W-1:0]       last_q, last_d;
`endif

    logic [N_REQ-1:0]      grant_oh;
    logic [ID_W-1:0]       grant_idx;
    logic [WIDTH-1:0]      sum_w;
    logic                  cout_w;
    logic [WIDTH-1:0]      a_arr [N_REQ];
    logic [WIDTH-1:0]      b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    adder_sched_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_valid_i (req_valid),
`ifdef ADDER_SCHED_RR_EN
        .last_i      (last_q),
`endif
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx)
    );

    BypassAdder_s_c #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) u_adder (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .cin_i  (op_cin_q),
        .sum_o  (sum_w),
        .cout_o (cout_w)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
`ifdef ADDER_SCHED_RR_EN
        last_d      = last_q;
`endif
        // Ready is offered only in IDLE and never while reset is asserted.
        req_ready   = (rst_n && state_q == IDLE) ? grant_oh : '0;

        case (state_q)
            IDLE: begin
                if (|grant_oh) begin
                    op_a_d   = a_arr[grant_idx];
                    op_b_d   = b_arr[grant_idx];
                    op_cin_d = req_cin[grant_idx];
                    op_id_d  = grant_idx;
                    cnt_d    = SETTLE_W'(SETTLE_CYCLES - 1);
`ifdef ADDER_SCHED_RR_EN
                    last_d   = grant_idx;
`endif
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_sum_d   = sum_w;
                    rsp_cout_d  = cout_w;
                    rsp_id_d    = op_id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
`ifdef ADDER_SCHED_RR_EN
            last_q      <= ID_W'(N_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
`ifdef ADDER_SCHED_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_sum     = rsp_sum_q;
    assign rsp_cout    = rsp_cout_q;
    assign rsp_id      = rsp_id_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: self-checking bench for adder_sched (N_REQ=4, WIDTH=32,
// BLOCK=4, SETTLE_CYCLES=2). Build option ADDER_SCHED_RR_EN selects the
// expected arbitration order.
module tb_adder_sched;
    import adder_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int EW = 2 + 1 + W;

    // ---------------- clock / reset / DUT ----------------
    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0] req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    state_t       dbg_state;

    adder_sched #(
        .N_REQ(N), .WIDTH(W), .BLOCK(4), .SETTLE_CYCLES(S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_cin     (req_cin),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_sum     (rsp_sum),
        .rsp_cout    (rsp_cout),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, expected one within the cycle budget", name);
    endfunction

    // Reference model: transaction-level view of the scheduler.
    typedef enum {M_IDLE, M_BUSY, M_RESP} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_last  = N - 1;
    int      m_wait  = 0;
    bit      mon_en  = 1'b0;
    int      dut_rsp_cnt = 0;
    int      dut_grant_cnt[N] = '{default: 0};

    function automatic logic [EW-1:0] model_rsp(int id, logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        return {2'(id), s};
    endfunction

    function automatic int model_pick(logic [N-1:0] v);
        logic [1:0] k;
`ifdef ADDER_SCHED_RR_EN
        for (int o = 1; o <= N; o++) begin
            k = 2'((m_last + o) % N);
            if (v[k]) return int'(k);
        end
`else
        for (int o = 0; o < N; o++) begin
            k = 2'(o);
            if (v[k]) return o;
        end
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [1:0]   wk;
        int           w;
        if (mon_en) begin
            exp_ready = '0;
            w = -1;
            wk = '0;
            if (rst_n && m_state == M_IDLE) begin
                w = model_pick(req_valid);
                if (w >= 0) begin
                    wk = 2'(w);
                    exp_ready[wk] = 1'b1;
                end
            end
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, m_state == M_RESP);
            if (m_state == M_RESP && exp_q.size() > 0)
                check("rsp_payload", {rsp_id, rsp_cout, rsp_sum}, exp_q[0]);

            if (rst_n && rsp_valid && rsp_ready) dut_rsp_cnt++;
            for (int i = 0; i < N; i++)
                if (rst_n && req_valid[i] && req_ready[i]) dut_grant_cnt[i]++;

            // Advance the model to the state after the coming rising edge.
            if (!rst_n) begin
                m_state = M_IDLE;
                m_last  = N - 1;
                exp_q.delete();
            end else begin
                case (m_state)
                    M_IDLE: if (w >= 0) begin
                        exp_q.push_back(model_rsp(w, req_a[wk*W +: W], req_b[wk*W +: W], req_cin[wk]));
                        m_last  = w;
                        m_wait  = S;
                        m_state = M_BUSY;
                    end
                    M_BUSY: begin
                        m_wait--;
                        if (m_wait == 0) m_state = M_RESP;
                    end
                    M_RESP: if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        m_state = M_IDLE;
                    end
                    default: m_state = M_IDLE;
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_set(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = c;
        req_valid[id]    = 1'b1;
    endtask

    task automatic req_clr(input int id);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                tick();
                req_clr(id);
                ok = 1'b1;
                return;
            end
        end
        timeout("grant_timeout");
        req_clr(id);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_rsp_sum"},   rsp_sum,   '0);
        check({tag, "_rsp_cout"},  rsp_cout,  1'b0);
        check({tag, "_rsp_id"},    rsp_id,    '0);
        check({tag, "_state"},     dbg_state, IDLE);
    endtask

    // One request through to its response; bp = cycles of held-off rsp_ready.
    task automatic single_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input int bp, input bit chk,
                             input logic [W-1:0] es, input logic ec);
        bit ok;
        int k;
        rsp_ready = (bp == 0);
        req_set(id, a, b, c);
        wait_grant(id, ok);
        if (!ok) return;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 40);
        if (!rsp_valid) begin
            timeout("rsp_timeout");
            rsp_ready = 1'b1;
            tick();
            return;
        end
        check("latency_edges", k - 1, S);
        if (chk) begin
            check("tbl_sum",  rsp_sum,  es);
            check("tbl_cout", rsp_cout, ec);
            check("tbl_id",   rsp_id,   id);
        end
        repeat (bp) tick();
        rsp_ready = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       cin;
        logic [W-1:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl[8];
    int   got[4];
    int   exp_grant[4];

    initial begin
        bit           ok;
        int           n;
        int           rsp0;
        int           g3;
        logic [N-1:0] mask;
        logic [N-1:0] g;

        tbl[0] = '{0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0};
        tbl[1] = '{2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1};
        tbl[2] = '{1, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
        tbl[3] = '{3, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tbl[4] = '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        tbl[5] = '{2, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        tbl[6] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[7] = '{3, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h0001FFFE, 1'b0};
`ifdef ADDER_SCHED_RR_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif

        // Reset with a request pending: ready must stay low.
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        req_set(1, 32'h1234, 32'h1, 1'b0);
        tick();
        mon_en = 1'b1;
        repeat (2) tick();
        check("reset_req_ready", req_ready, '0);
        rst_n = 1'b1;
        req_clr(1);
        check_reset_outputs("reset");

        // Contention: req0 and req1 held valid across four grants.
        req_set(0, 32'h5, 32'h6, 1'b0);
        req_set(1, 32'h7, 32'h8, 1'b1);
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (req_ready[1:0] != 2'b00) begin
                got[n] = req_ready[1] ? 1 : 0;
                n++;
                if (n == 4) tick();
            end
        end
        req_clr(0);
        req_clr(1);
        if (n < 4) timeout("contention_grants");
        for (int i = 0; i < n; i++) check("contention_grant", got[i], exp_grant[i]);
        repeat (S + 3) tick();

        // Table vectors with hand-computed results.
        for (int i = 0; i < 8; i++)
            single_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, i % 3, 1'b1, tbl[i].sum, tbl[i].cout);

        // Backpressure with a withdrawn req3 during RESP.
        rsp0 = dut_rsp_cnt;
        g3   = dut_grant_cnt[3];
        rsp_ready = 1'b0;
        req_set(2, 32'h0000FFFF, 32'h00000001, 1'b0);
        wait_grant(2, ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        if (!rsp_valid) timeout("bp_rsp_timeout");
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) req_set(3, 32'h3, 32'h3, 1'b0);
            @(negedge clk);
            check("bp_sum",   rsp_sum,   32'h00010000);
            check("bp_cout",  rsp_cout,  1'b0);
            check("bp_id",    rsp_id,    2'd2);
            check("bp_ready", req_ready, '0);
        end
        tick();
        req_clr(3);
        rsp_ready = 1'b1;
        repeat (4) tick();
        check("bp_one_response", dut_rsp_cnt - rsp0, 1);
        check("withdrawn_no_grant", dut_grant_cnt[3], g3);

        // Randomized single operations.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
            single_op($urandom_range(0, N - 1), ra, rb, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 1'b0, '0, 1'b0);
        end

        // Randomized bursts of simultaneous requests with random backpressure.
        for (int r = 0; r < 15; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                if (mask[i]) req_set(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 300 && mask != '0; k++) begin
                @(negedge clk);
                g = req_ready & mask;
                tick();
                for (int i = 0; i < N; i++)
                    if (g[i]) begin
                        req_clr(i);
                        mask[i] = 1'b0;
                    end
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (mask != '0) timeout("burst_grants");
            req_valid = '0;
            rsp_ready = 1'b1;
            repeat (S + 3) tick();
        end

        // Reset mid-SETTLE aborts the operation.
        single_op(3, 32'hDEADBEEF, 32'h11111111, 1'b1, 0, 1'b0, '0, 1'b0);
        rsp0 = dut_rsp_cnt;
        req_set(2, 32'h0F0F0F0F, 32'h01010101, 1'b0);
        wait_grant(2, ok);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("midsettle");
        check("midsettle_req_ready", req_ready, '0);
        repeat (S + 4) tick();
        check("midsettle_no_rsp", dut_rsp_cnt, rsp0);

        req_set(0, 32'h10, 32'h20, 1'b0);
        req_set(3, 32'h30, 32'h40, 1'b1);
        n = 0;
        for (int k = 0; k < 40 && n == 0; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("post_reset_first_grant", req_ready, 4'b0001);
                n = 1;
                tick();
            end
        end
        req_clr(0);
        req_clr(3);
        if (n == 0) timeout("post_reset_grant");
        repeat (S + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
